// File: rtl/spi_frame_tx.sv
// Mode-0 SPI frame transmitter: snapshots a DATA_W-bit word and shifts it out MSB-first
// over NB bytes under one slave-select window. Define SPI_FRAME_CRC_EN to append a CRC-8 trailer.
module spi_frame_tx #(
  parameter int DATA_W  = 14,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [((DATA_W+7)/8)*8-1:0]     rx_data,
  output logic                            done,
  output logic                            crc_err,
  output logic                            busy,
  output logic                            sclk,
  output logic                            mosi,
  input  logic                            miso,
  output logic                            ss,
  output logic [2:0]                      dbg_state
);

  localparam int NB = (DATA_W + 7) / 8;
  localparam int PW = NB * 8;
`ifdef SPI_FRAME_CRC_EN
  localparam int NBYTES = NB + 1;
`else
  localparam int NBYTES = NB;
`endif
  localparam int FW = NBYTES * 8;
  localparam int CW = 16;
  localparam int BW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_GAP   = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [BW-1:0] byte_q, byte_d;
  logic          sclk_q, sclk_d;
  logic [FW-1:0] tx_q, tx_d;
  logic [FW-1:0] rx_q, rx_d;
  logic [PW-1:0] rx_data_q, rx_data_d;
  logic          done_q, done_d;
  logic [PW-1:0] pay;
  logic [FW-1:0] load_frame;

  assign pay = PW'(in_data);

`ifdef SPI_FRAME_CRC_EN
  logic crc_err_q, crc_err_d;

  // Bit-serial CRC-8, poly 0x07, init 0, MSB first, no reflection or final XOR.
  function automatic logic [7:0] crc8(input logic [PW-1:0] msg);
    logic [7:0] c;
    c = 8'h00;
    for (int i = PW - 1; i >= 0; i--) begin
      if (c[7] ^ msg[i]) c = {c[6:0], 1'b0} ^ 8'h07;
      else               c = {c[6:0], 1'b0};
    end
    return c;
  endfunction

  assign load_frame = {pay, crc8(pay)};
  assign crc_err    = crc_err_q;
`else
  assign load_frame = pay;
  assign crc_err    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    sclk_d    = sclk_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
`ifdef SPI_FRAME_CRC_EN
    crc_err_d = crc_err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_SETUP;
          tx_d    = load_frame;
          byte_d  = BW'(NBYTES);
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_SETUP: begin
        if (cnt_q == DIV_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHIFT: begin
        if (cnt_q != DIV_LAST) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!sclk_q) begin
            // Rising edge: capture miso.
            sclk_d = 1'b1;
            rx_d   = {rx_q[FW-2:0], miso};
          end else begin
            // Falling edge: advance mosi and the bit/byte position.
            sclk_d = 1'b0;
            tx_d   = {tx_q[FW-2:0], 1'b0};
            bit_d  = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
              byte_d = byte_q - BW'(1);
              if (byte_q == BW'(1))  state_d = S_HOLD;
              else if (GAP_CYC != 0) state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == DIV_LAST) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          done_d    = 1'b1;
          rx_data_d = rx_q[FW-1 -: PW];
`ifdef SPI_FRAME_CRC_EN
          crc_err_d = (crc8(rx_q[FW-1 -: PW]) != rx_q[7:0]);
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      sclk_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      sclk_q    <= sclk_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
    end
  end

`ifdef SPI_FRAME_CRC_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) crc_err_q <= 1'b0;
    else        crc_err_q <= crc_err_d;
  end
`endif

  // Handshake: a word is taken on any clk edge where in_valid and in_ready are both high;
  // in_ready is high only in IDLE, so in_valid is ignored while a frame is in flight.
  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign ss        = (state_q == S_IDLE);
  assign sclk      = sclk_q;
  assign mosi      = (state_q != S_IDLE) & tx_q[FW-1];
  assign done      = done_q;
  assign rx_data   = rx_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: two instances (14b/div2/gap1 and 20b/div1/gap0) against an SPI-slave
// monitor, a frame-level reference model and an expected-frame scoreboard.
`timescale 1ns/1ps
module tb_spi_frame_tx;

  localparam int DW_A = 14, DIV_A = 2, GAP_A = 1, NB_A = 2;
  localparam int DW_B = 20, DIV_B = 1, GAP_B = 0, NB_B = 3;
`ifdef SPI_FRAME_CRC_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW_A-1:0] din_a = '0;
  logic [DW_B-1:0] din_b = '0;
  logic [1:0]  valid_w = '0;
  logic [1:0]  miso_w = '0;
  logic [15:0] rx_a;
  logic [23:0] rx_b;
  logic [2:0]  dbg_a, dbg_b;
  logic ready_a, ready_b, done_a, done_b, crc_a, crc_b, busy_a, busy_b;
  logic sclk_a, sclk_b, mosi_a, mosi_b, ss_a, ss_b;
  logic [1:0] ready_w, done_w, crc_w, busy_w, sclk_w, mosi_w, ss_w;
  assign ready_w = {ready_b, ready_a};
  assign done_w  = {done_b, done_a};
  assign crc_w   = {crc_b, crc_a};
  assign busy_w  = {busy_b, busy_a};
  assign sclk_w  = {sclk_b, sclk_a};
  assign mosi_w  = {mosi_b, mosi_a};
  assign ss_w    = {ss_b, ss_a};

  spi_frame_tx #(.DATA_W(DW_A), .CLK_DIV(DIV_A), .GAP_CYC(GAP_A)) dut_a (
    .clk(clk), .reset(reset), .in_data(din_a), .in_valid(valid_w[0]), .in_ready(ready_a),
    .rx_data(rx_a), .done(done_a), .crc_err(crc_a), .busy(busy_a), .sclk(sclk_a),
    .mosi(mosi_a), .miso(miso_w[0]), .ss(ss_a), .dbg_state(dbg_a));

  spi_frame_tx #(.DATA_W(DW_B), .CLK_DIV(DIV_B), .GAP_CYC(GAP_B)) dut_b (
    .clk(clk), .reset(reset), .in_data(din_b), .in_valid(valid_w[1]), .in_ready(ready_b),
    .rx_data(rx_b), .done(done_b), .crc_err(crc_b), .busy(busy_b), .sclk(sclk_b),
    .mosi(mosi_b), .miso(miso_w[1]), .ss(ss_b), .dbg_state(dbg_b));

  // checking
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // reference model: whole-frame arithmetic
  function automatic logic [7:0] ref_crc(input logic [31:0] msg, input int nb);
    logic [39:0] r;
    r = {msg, 8'h00};
    for (int i = nb * 8 + 7; i >= 8; i--)
      if (r[i]) r = r ^ (40'h107 << (i - 8));
    return r[7:0];
  endfunction

  function automatic logic [31:0] ref_frame(input logic [31:0] d, input int nb);
    if (CRC_ON != 0) return (d << 8) | 32'(ref_crc(d, nb));
    return d;
  endfunction

  typedef struct {
    int          dut;
    logic [31:0] frame;
    int          nbits;
    int          ss_len;
    logic [23:0] rx;
    logic        crc_err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] miso_q[$];

  task automatic push_frame(input int k, input logic [31:0] d, input logic [31:0] mv_in);
    exp_t e;
    int nb, dv, gp, b;
    logic [31:0] mv;
    nb = (k == 0) ? NB_A : NB_B;
    dv = (k == 0) ? DIV_A : DIV_B;
    gp = (k == 0) ? GAP_A : GAP_B;
    b  = nb + CRC_ON;
    mv = (b == 4) ? mv_in : (mv_in & ((32'd1 << (b * 8)) - 32'd1));
    e.dut    = k;
    e.frame  = ref_frame(d, nb);
    e.nbits  = b * 8;
    e.ss_len = dv + b * 16 * dv + (b - 1) * gp + dv;
    if (CRC_ON != 0) begin
      e.rx      = 24'(mv >> 8);
      e.crc_err = (ref_crc(mv >> 8, nb) != mv[7:0]);
    end else begin
      e.rx      = 24'(mv);
      e.crc_err = 1'b0;
    end
    exp_q.push_back(e);
    miso_q.push_back(mv);
  endtask

  // SPI slave monitor
  int          low_cnt[2], high_cnt[2], last_gap[2], nbits[2], idx[2];
  int          rise_cyc[2], per_min[2], per_max[2], done_cnt[2];
  logic [31:0] bits[2], mvec[2];
  logic        ss_prev[2], sclk_prev[2], rdy_bad[2], done_prev[2];
  int          pos, per;

  initial begin
    for (int k = 0; k < 2; k++) begin
      low_cnt[k] = 0; high_cnt[k] = 0; last_gap[k] = 0; nbits[k] = 0; idx[k] = 0;
      rise_cyc[k] = -1; per_min[k] = 0; per_max[k] = 0; done_cnt[k] = 0;
      bits[k] = '0; mvec[k] = '0; ss_prev[k] = 1'b1; sclk_prev[k] = 1'b0;
      rdy_bad[k] = 1'b0; done_prev[k] = 1'b0;
    end
  end

  task automatic frame_end(input int k);
    exp_t e;
    logic [31:0] rxv;
    if (exp_q.size() == 0) begin
      check("done_expected", 32'(exp_q.size()), 32'd1);
      return;
    end
    e   = exp_q.pop_front();
    rxv = (k == 0) ? {16'h0, rx_a} : {8'h0, rx_b};
    check("dut_id", k, e.dut);
    check("mosi_nbits", nbits[k], e.nbits);
    check("mosi_bits", bits[k], e.frame);
    check("ss_len", low_cnt[k], e.ss_len);
    check("rx_data", rxv, e.rx);
    check("crc_err", crc_w[k], e.crc_err);
    check("ready_in_frame", rdy_bad[k], 0);
    check("ready_at_done", ready_w[k], 1);
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        ss_prev[k] = 1'b1; sclk_prev[k] = 1'b0; done_prev[k] = 1'b0; high_cnt[k] = 0;
      end else begin
        if (!ss_w[k]) begin
          if (ss_prev[k]) begin
            last_gap[k] = high_cnt[k];
            low_cnt[k] = 0; nbits[k] = 0; bits[k] = '0; idx[k] = 0; rdy_bad[k] = 1'b0;
            per_min[k] = 1000; per_max[k] = 0; rise_cyc[k] = -1;
            mvec[k] = (miso_q.size() > 0) ? miso_q.pop_front() : 32'h0;
          end
          low_cnt[k]++;
          if (ready_w[k]) rdy_bad[k] = 1'b1;
          if (sclk_w[k] && !sclk_prev[k]) begin
            bits[k] = {bits[k][30:0], mosi_w[k]};
            nbits[k]++;
            idx[k]++;
            if (rise_cyc[k] >= 0) begin
              per = cyc - rise_cyc[k];
              if (per < per_min[k]) per_min[k] = per;
              if (per > per_max[k]) per_max[k] = per;
            end
            rise_cyc[k] = cyc;
          end
          pos = (((k == 0) ? NB_A : NB_B) + CRC_ON) * 8 - 1 - idx[k];
          miso_w[k] = (pos >= 0) ? mvec[k][pos] : 1'b0;
        end else begin
          if (!ss_prev[k]) begin
            check("done_at_ss_rise", done_w[k], 1);
            high_cnt[k] = 0;
          end
          high_cnt[k]++;
        end
        if (done_w[k]) begin
          check("done_one_cycle", done_prev[k], 0);
          done_cnt[k]++;
          frame_end(k);
        end
        ss_prev[k] = ss_w[k]; sclk_prev[k] = sclk_w[k]; done_prev[k] = done_w[k];
      end
    end
  end

  // driver tasks
  task automatic drive(input int k, input logic [31:0] d);
    int t;
    @(negedge clk);
    if (k == 0) din_a = d[DW_A-1:0];
    else        din_b = d[DW_B-1:0];
    valid_w[k] = 1'b1;
    t = 0;
    while (!ready_w[k] && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("accept_timeout", ready_w[k], 1);
    @(posedge clk);
    #1;
    valid_w[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int n);
    int start, t;
    start = done_cnt[k];
    t = 0;
    while (done_cnt[k] < start + n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 2000) check("done_timeout", done_cnt[k] - start, n);
  endtask

  task automatic send_frame(input int k, input logic [31:0] d, input logic [31:0] mv);
    push_frame(k, d, mv);
    drive(k, d);
    wait_done(k, 1);
  endtask

  typedef struct {
    logic [13:0] data;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic        loop;
  } vec_t;

  initial begin : watchdog
    #(400_000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t tbl[5];
    logic [31:0] d, mv;
    int d0, t;

    tbl[0] = '{14'h2ABC, 8'h2A, 8'hBC, 1'b1};
    tbl[1] = '{14'h1234, 8'h12, 8'h34, 1'b1};
    tbl[2] = '{14'h0001, 8'h00, 8'h01, 1'b1};
    tbl[3] = '{14'h3FFF, 8'h3F, 8'hFF, 1'b1};
    tbl[4] = '{14'h0055, 8'h00, 8'h55, 1'b0};

    // reset values while reset is held
    repeat (3) @(negedge clk);
    check("rst_ss", ss_w, 2'b11);
    check("rst_sclk", sclk_w, 2'b00);
    check("rst_mosi", mosi_w, 2'b00);
    check("rst_done", done_w, 2'b00);
    check("rst_busy", busy_w, 2'b00);
    check("rst_crc", crc_w, 2'b00);
    check("rst_rx_a", rx_a, 0);
    check("rst_rx_b", rx_b, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_ready", ready_w, 2'b11);

    // table-driven frames on the 14-bit instance
    for (int i = 0; i < 5; i++) begin
      d  = 32'(tbl[i].data);
      mv = tbl[i].loop ? ref_frame(d, NB_A) : 32'hA55A_5AA5;
      send_frame(0, d, mv);
      check("tbl_mosi", bits[0] >> (8 * CRC_ON), {16'h0, tbl[i].b0, tbl[i].b1});
      check("tbl_ss_len", low_cnt[0], (CRC_ON != 0) ? 102 : 69);
      if (tbl[i].loop) check("tbl_rx", {16'h0, rx_a}, 32'(tbl[i].data));
    end

    // trailer frame for 0x0001, then the same frame with a corrupted last miso bit
    send_frame(0, 32'h1, ref_frame(32'h1, NB_A));
    check("crc_frame", bits[0], (CRC_ON != 0) ? 32'h107 : 32'h1);
    check("crc_ok", crc_a, 0);
    send_frame(0, 32'h1, ref_frame(32'h1, NB_A) ^ 32'h1);
    check("crc_bad", crc_a, CRC_ON);

    // back-to-back: in_valid held, in_data changed right after the first accept
    push_frame(0, 32'h0001, ref_frame(32'h0001, NB_A));
    push_frame(0, 32'h3FFF, ref_frame(32'h3FFF, NB_A));
    @(negedge clk);
    din_a = 14'h0001;
    valid_w[0] = 1'b1;
    @(posedge clk);
    #1;
    din_a = 14'h3FFF;
    @(negedge clk);
    t = 0;
    while (!ready_a && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("b2b_accept", ready_a, 1);
    @(posedge clk);
    #1;
    valid_w[0] = 1'b0;
    wait_done(0, 1);
    check("b2b_ss_gap", last_gap[0], 1);

    // mid-frame reset during the second byte
    drive(0, 32'h2ABC);
    @(posedge clk);
    t = 0;
    while (nbits[0] < 9 && t < 1000) begin
      @(posedge clk);
      t++;
    end
    check("abort_reached_byte2", (nbits[0] >= 9), 1);
    @(negedge clk);
    #2;
    d0 = done_cnt[0];
    reset = 1'b0;
    #1;
    check("abort_ss", ss_a, 1);
    check("abort_sclk", sclk_a, 0);
    check("abort_mosi", mosi_a, 0);
    check("abort_rx", rx_a, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", ready_a, 1);
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt[0], d0);
    send_frame(0, 32'h0055, ref_frame(32'h0055, NB_A));
    check("post_abort_mosi", bits[0] >> (8 * CRC_ON), 32'h0055);

    // randomized frames on the 14-bit instance
    for (int i = 0; i < 20; i++) begin
      d  = 32'($urandom_range(0, 16383));
      mv = ($urandom_range(0, 1) == 1) ? ref_frame(d, NB_A) : $urandom;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(0, d, mv);
    end

    // 20-bit instance, CLK_DIV=1
    send_frame(1, 32'hABCDE, ref_frame(32'hABCDE, NB_B));
    check("b_mosi", bits[1] >> (8 * CRC_ON), 32'h0ABCDE);
    check("b_rx", {8'h0, rx_b}, 32'h0ABCDE);
    check("b_sclk_per_min", per_min[1], 2);
    check("b_sclk_per_max", per_max[1], 2);
    check("b_ss_len", low_cnt[1], (CRC_ON != 0) ? 66 : 50);
    for (int i = 0; i < 8; i++) begin
      d  = 32'($urandom_range(0, 20'hFFFFF));
      mv = ($urandom_range(0, 1) == 1) ? ref_frame(d, NB_B) : $urandom;
      send_frame(1, d, mv);
    end

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
